regfile_wb_arbiter: RTL

//  Writer-side front end of the core register file: collects writeback results from the ALU,
//  the load/store unit (LSU) and the mul/div unit (MD), and drives the register file's single

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_wb_arbiter_if.sv | 55 +++++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 67 ++++++
 rtl/regfile_wb_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 5;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_STARVE_MAX = 3;

  // One buffered writeback: destination index plus data.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Which source drives the write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_t;

  // A non-zero source index that matches a destination is a hazard; x0 never is.
  function automatic logic rd_match(input logic [ADDR_W-1:0] src,
                                    input logic [ADDR_W-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: ALU/LSU/MD producers, register-file write port and decode hazard query.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;

  logic              md_valid;
  logic              md_ready;
  logic [ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0] md_data;

  logic              we;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] result;

  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic              pend_a;
  logic              pend_b;

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_stall,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  md_valid, md_rd, md_data,
    output md_ready,
    output we, write_addr, result,
    input  src_a, src_b,
    output pend_a, pend_b
  );

  // Producer / register-file / decode side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_stall,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output md_valid, md_rd, md_data,
    input  md_ready,
    input  we, write_addr, result,
    output src_a, src_b,
    input  pend_a, pend_b
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// In-order sync FIFO of writeback entries with a per-slot valid/rd view for hazard matching.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  wb_entry_t                     i_push_data,
  input  logic                          i_pop,
  output wb_entry_t                     o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [DEPTH-1:0]              o_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]  o_rd
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_vld;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_vld     = r_vld;

  // Pointers, occupancy and slot-valid bits; reset drops every buffered entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
      if (w_pop_ok)  r_vld[r_rd_ptr] <= 1'b0;
      if (w_push_ok) r_vld[r_wr_ptr] <= 1'b1;
    end
  end

  // Payload storage; contents only matter where the slot-valid bit is set.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Expose each slot's destination for the hazard comparators.
  always_comb begin
    o_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_rd[i] = r_mem[i].rd;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU-priority select onto the register-file write port,
// LSU/MD results buffered in a shared FIFO, starvation guard and hazard flags.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

  wb_src_t                            w_sel;
  logic                               w_lsu_fire;
  logic                               w_md_fire;
  logic                               w_push;
  wb_entry_t                          w_push_data;
  logic                               w_pop;
  wb_entry_t                          w_head;
  logic                               w_full;
  logic                               w_empty;
  logic [FIFO_DEPTH-1:0]              w_vld;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]  w_fifo_rd;
  logic                               w_alu_over_fifo;
  logic                               w_starve_hit;
  logic                               w_pend_a;
  logic                               w_pend_b;

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_result;
  logic              r_alu_stall;
  logic [CNT_W-1:0]  r_starve_cnt;

  // Ready comes from the pre-pop full flag; LSU wins a simultaneous push.
  assign bus.lsu_ready = !w_full;
  assign w_lsu_fire    = bus.lsu_valid && bus.lsu_ready;
  assign bus.md_ready  = !w_full && !w_lsu_fire;
  assign w_md_fire     = bus.md_valid && bus.md_ready;

  // Pick at most one accepted producer; x0 destinations complete but are not buffered.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    if (w_lsu_fire) begin
      w_push           = (bus.lsu_rd != '0);
      w_push_data.rd   = bus.lsu_rd;
      w_push_data.data = bus.lsu_data;
    end else if (w_md_fire) begin
      w_push           = (bus.md_rd != '0);
      w_push_data.rd   = bus.md_rd;
      w_push_data.data = bus.md_data;
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_vld       (w_vld),
    .o_rd        (w_fifo_rd)
  );

  // Write-port source: a presented ALU result always wins (stall only asks upstream to hold off).
  always_comb begin
    w_sel = SRC_NONE;
    if (bus.alu_valid) begin
      w_sel = SRC_ALU;
    end else if (!w_empty) begin
      w_sel = SRC_FIFO;
    end
  end

  assign w_pop           = (w_sel == SRC_FIFO);
  assign w_alu_over_fifo = (w_sel == SRC_ALU) && !w_empty;
  assign w_starve_hit    = w_alu_over_fifo && (r_starve_cnt == CNT_W'(STARVE_MAX - 1));

  // Register-file write port, loaded from this cycle's selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_result <= '0;
    end else begin
      r_we <= 1'b0;
      unique case (w_sel)
        SRC_ALU: begin
          r_we     <= (bus.alu_rd != '0);
          r_waddr  <= bus.alu_rd;
          r_result <= bus.alu_data;
        end
        SRC_FIFO: begin
          r_we     <= 1'b1;
          r_waddr  <= w_head.rd;
          r_result <= w_head.data;
        end
        default: begin
        end
      endcase
    end
  end

  // Count consecutive ALU wins over a waiting FIFO; on the limit stall the ALU for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_alu_stall  <= 1'b0;
    end else if (w_starve_hit) begin
      r_starve_cnt <= '0;
      r_alu_stall  <= 1'b1;
    end else if (w_alu_over_fifo) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      r_alu_stall  <= 1'b0;
    end else begin
      r_starve_cnt <= '0;
      r_alu_stall  <= 1'b0;
    end
  end

  // Operand hazards against buffered entries and the write in flight.
  always_comb begin
    w_pend_a = rd_match(bus.src_a, r_waddr) && r_we;
    w_pend_b = rd_match(bus.src_b, r_waddr) && r_we;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_vld[i] && rd_match(bus.src_a, w_fifo_rd[i])) w_pend_a = 1'b1;
      if (w_vld[i] && rd_match(bus.src_b, w_fifo_rd[i])) w_pend_b = 1'b1;
    end
  end

  assign bus.we         = r_we;
  assign bus.write_addr = r_waddr;
  assign bus.result     = r_result;
  assign bus.alu_stall  = r_alu_stall;
  assign bus.pend_a     = w_pend_a;
  assign bus.pend_b     = w_pend_b;

  // Upstream must keep the ALU quiet while stalled; the result is still taken if it does not.
  a_alu_stall_protocol : assert property (
    @(posedge clk) disable iff (rst) !(bus.alu_valid && r_alu_stall)
  ) else $error("alu_valid asserted while alu_stall is high");

endmodule
